// File: rtl/pcim_result_writer_if.sv
// PCIM AXI4 write channels plus the 512-bit result stream feeding them.
// master = the writer (drives AW/W, consumes the stream); slave = host side / stream source.
interface pcim_result_writer_if;
    logic [511:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;

    logic [15:0]  m_axi_awid;
    logic [63:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic         m_axi_awvalid;
    logic         m_axi_awready;

    logic [511:0] m_axi_wdata;
    logic [63:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;

    logic [15:0]  m_axi_bid;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;

    modport master (
        input  s_tdata, s_tvalid,
        output s_tready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output s_tdata, s_tvalid,
        input  s_tready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/pcim_result_writer.sv
// Streams CNN result beats into host memory as incrementing PCIM AXI4 write bursts.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for cfg_start; zero-length / misaligned jobs end here
//   S_ADDR   | presenting AW for the next burst once the outstanding limit allows
//   S_DATA   | passing stream beats straight onto W until wlast handshakes
//   S_DRAIN  | all data sent, waiting for the remaining B responses
module pcim_result_writer #(
    parameter int          BURST_BEATS     = 16,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] AXI_ID          = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic [63:0]                  cfg_base_addr,
    input  logic [31:0]                  cfg_num_beats,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    pcim_result_writer_if.master         bus
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ADDR  = 2'd1;
    localparam logic [1:0]  S_DATA  = 2'd2;
    localparam logic [1:0]  S_DRAIN = 2'd3;

    localparam logic [63:0] ALIGN_BYTES = 64'(BURST_BEATS) * 64'd64;
    localparam logic [31:0] BURST_W     = 32'(BURST_BEATS);
    localparam logic [3:0]  MAX_OUT     = 4'(MAX_OUTSTANDING);

    logic [1:0]  state;
    logic [63:0] addr;
    logic [31:0] remaining;
    logic [3:0]  outstanding;
    logic [3:0]  outstanding_nxt;
    logic [7:0]  awlen_q;
    logic [7:0]  beat_cnt;
    logic [7:0]  awlen_c;
    logic [8:0]  burst_len;
    logic [31:0] rem_after;
    logic        aw_hs, w_hs, b_hs, b_dec, misaligned;
    logic        unused_bid;

    assign unused_bid = ^bus.m_axi_bid;

    assign awlen_c    = (remaining >= BURST_W) ? 8'(BURST_BEATS - 1) : remaining[7:0] - 8'd1;
    assign burst_len  = {1'b0, awlen_q} + 9'd1;
    // awlen_q+1 never exceeds remaining, so this cannot wrap below zero
    assign rem_after  = remaining - 32'(burst_len);
    assign misaligned = (cfg_base_addr % ALIGN_BYTES) != 64'd0;

    assign aw_hs = bus.m_axi_awvalid & bus.m_axi_awready;
    assign w_hs  = bus.m_axi_wvalid & bus.m_axi_wready;
    assign b_hs  = bus.m_axi_bvalid & bus.m_axi_bready;
    assign b_dec = b_hs && (outstanding != 4'd0);

    always_comb begin
        outstanding_nxt = outstanding;
        if (aw_hs && !b_dec)
            outstanding_nxt = outstanding + 4'd1;
        else if (!aw_hs && b_dec)
            outstanding_nxt = outstanding - 4'd1;
    end

    // AW fields only move in S_DATA, so they stay stable while awvalid waits for awready
    assign bus.m_axi_awid    = AXI_ID;
    assign bus.m_axi_awaddr  = addr;
    assign bus.m_axi_awlen   = (state == S_ADDR) ? awlen_c : 8'd0;
    assign bus.m_axi_awsize  = 3'b110;
    assign bus.m_axi_awvalid = (state == S_ADDR) && (outstanding < MAX_OUT);

    assign bus.m_axi_wdata   = bus.s_tdata;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wvalid  = (state == S_DATA) && bus.s_tvalid;
    assign bus.m_axi_wlast   = (state == S_DATA) && (beat_cnt == awlen_q);
    assign bus.s_tready      = (state == S_DATA) && bus.m_axi_wready;
    assign bus.m_axi_bready  = rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr        <= 64'd0;
            remaining   <= 32'd0;
            outstanding <= 4'd0;
            awlen_q     <= 8'd0;
            beat_cnt    <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            outstanding <= outstanding_nxt;
            if (b_hs && (bus.m_axi_bresp != 2'b00))
                err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        addr      <= cfg_base_addr;
                        remaining <= cfg_num_beats;
                        beat_cnt  <= 8'd0;
                        if (cfg_num_beats == 32'd0) begin
                            err  <= 1'b0;
                            done <= 1'b1;
                        end else if (misaligned) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (aw_hs) begin
                        awlen_q  <= awlen_c;
                        beat_cnt <= 8'd0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (bus.m_axi_wlast) begin
                            addr      <= addr + 64'({burst_len, 6'b0});
                            remaining <= rem_after;
                            beat_cnt  <= 8'd0;
                            state     <= (rem_after == 32'd0) ? S_DRAIN : S_ADDR;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (outstanding_nxt == 4'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcim_result_writer.sv
// Self-checking bench: job table plus a reset-in-flight sequence, with an AXI slave/stream model
// and AW/W scoreboards.
module tb_pcim_result_writer;
    localparam int BB = 16;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [63:0] cfg_base_addr = 64'd0;
    logic [31:0] cfg_num_beats = 32'd0;
    logic        busy, done, err;

    pcim_result_writer_if bif();

    pcim_result_writer #(.BURST_BEATS(BB), .MAX_OUTSTANDING(MO), .AXI_ID(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_beats (cfg_num_beats),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .bus           (bif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [511:0] data; logic last; } w_t;
    typedef struct {
        logic [63:0] base;
        logic [31:0] beats;
        int          stall;
        bit          berr;
        bit          hold;
        bit          exp_err;
    } job_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];

    function automatic logic [511:0] pat(input int i);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'(i) * 32'h9E37_79B9 + 32'(k);
        return r;
    endfunction

    // slave / stream model state
    int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, b_cnt = 0, b_issued = 0, done_cnt = 0;
    int cyc = 0, last_b_cyc = 0;
    int src_idx = 0, src_total = 0, exp_idx = 0;
    int aw_stall = 0;
    int err_b_at = -1;
    bit b_hold = 1'b0;
    bit resync = 1'b0;
    bit aw_prev = 1'b0;
    bit src_hs;
    logic [63:0] aw_prev_addr;
    logic [7:0]  aw_prev_len;

    initial begin : slave
        aw_t e;
        w_t  ew;
        bif.s_tvalid = 1'b0;
        bif.s_tdata = '0;
        bif.m_axi_awready = 1'b0;
        bif.m_axi_wready = 1'b0;
        bif.m_axi_bvalid = 1'b0;
        bif.m_axi_bresp = 2'b00;
        bif.m_axi_bid = 16'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (resync) begin
                aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; b_cnt = 0; b_issued = 0;
                src_total = src_idx;
                aw_prev = 1'b0;
                resync = 1'b0;
            end
            if (aw_prev) begin
                chk("aw_hold_valid", bif.m_axi_awvalid, 1'b1);
                chk("aw_hold_addr", bif.m_axi_awaddr, aw_prev_addr);
                chk("aw_hold_len", bif.m_axi_awlen, aw_prev_len);
            end
            if (bif.m_axi_awvalid && bif.m_axi_awready) begin
                chk("aw_outstanding", (aw_cnt - b_cnt) < MO, 1'b1);
                chk("aw_size", bif.m_axi_awsize, 3'b110);
                if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_aw.pop_front();
                    chk("aw_addr", bif.m_axi_awaddr, e.addr);
                    chk("aw_len", bif.m_axi_awlen, e.len);
                end
                aw_cnt++;
            end
            aw_prev = bif.m_axi_awvalid && !bif.m_axi_awready;
            aw_prev_addr = bif.m_axi_awaddr;
            aw_prev_len = bif.m_axi_awlen;
            if (bif.m_axi_awvalid) chk("w_idle_in_addr", {bif.m_axi_wvalid, bif.s_tready}, 2'b00);
            if (bif.m_axi_wvalid && bif.m_axi_wready) begin
                chk("w_after_aw", aw_cnt > wlast_cnt, 1'b1);
                chk("w_strb", bif.m_axi_wstrb, {64{1'b1}});
                if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
                else begin
                    ew = exp_w.pop_front();
                    chk("w_data", bif.m_axi_wdata, ew.data);
                    chk("w_last", bif.m_axi_wlast, ew.last);
                end
                w_cnt++;
                if (bif.m_axi_wlast) wlast_cnt++;
            end
            src_hs = bif.s_tvalid && bif.s_tready;
            if (bif.m_axi_bvalid && bif.m_axi_bready) begin
                b_cnt++;
                last_b_cyc = cyc;
            end
            if (done) done_cnt++;

            @(posedge clk);
            #1;
            if (src_hs) src_idx++;
            bif.s_tvalid = (src_idx < src_total) && ($urandom_range(0, 3) != 0);
            bif.s_tdata = pat(src_idx);
            if (aw_stall > 0) begin
                if (bif.m_axi_awvalid) aw_stall--;
                bif.m_axi_awready = 1'b0;
            end else begin
                bif.m_axi_awready = ($urandom_range(0, 2) != 0);
            end
            bif.m_axi_wready = ($urandom_range(0, 3) != 0);
            if (bif.m_axi_bvalid) begin
                bif.m_axi_bvalid = 1'b0;
            end else if (!b_hold && wlast_cnt > b_issued) begin
                bif.m_axi_bvalid = 1'b1;
                bif.m_axi_bresp = (b_issued == err_b_at) ? 2'b10 : 2'b00;
                b_issued++;
            end
        end
    end

    task automatic start_job(input logic [63:0] base, input logic [31:0] beats);
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        cfg_base_addr = base;
        cfg_num_beats = beats;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [63:0] base, input int beats, output int n_aw);
        logic [63:0] a = base;
        int rem = beats;
        int n;
        n_aw = 0;
        while (rem > 0) begin
            n = (rem > BB) ? BB : rem;
            exp_aw.push_back('{a, 8'(n - 1)});
            for (int i = 0; i < n; i++) begin
                exp_w.push_back('{pat(exp_idx), (i == n - 1)});
                exp_idx++;
            end
            a = a + 64'(n * 64);
            rem -= n;
            n_aw++;
        end
        src_total += beats;
    endtask

    task automatic run_job(input job_t j);
        int n_aw, aw0, w0, b0;
        bit valid, got;
        valid = (j.beats != 0) && ((j.base % 64'(BB * 64)) == 64'd0);
        n_aw = 0;
        if (valid) push_expected(j.base, int'(j.beats), n_aw);
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        aw_stall = j.stall;
        err_b_at = j.berr ? b_issued : -1;
        b_hold = j.hold;
        start_job(j.base, j.beats);
        if (!valid) begin
            chk("short_done", done, 1'b1);
            chk("short_busy", busy, 1'b0);
            chk("short_err", err, j.exp_err);
            @(negedge clk);
            chk("short_done_pulse", done, 1'b0);
            repeat (5) @(negedge clk);
            #1;
            chk("short_no_aw", aw_cnt - aw0, 0);
            return;
        end
        chk("start_busy", busy, 1'b1);
        chk("start_err_clear", err, 1'b0);
        chk("start_done", done, 1'b0);
        if (j.hold) begin
            got = 1'b0;
            for (int t = 0; t < 500; t++) begin
                @(negedge clk);
                #1;
                if (aw_cnt - aw0 >= MO) begin got = 1'b1; break; end
            end
            chk("hold_reach_limit", got, 1'b1);
            repeat (60) @(negedge clk);
            #1;
            chk("hold_aw_count", aw_cnt - aw0, MO);
            chk("hold_awvalid", bif.m_axi_awvalid, 1'b0);
            b_hold = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            #1;
            if (done) begin got = 1'b1; break; end
        end
        chk("done_seen", got, 1'b1);
        if (!got) return;
        chk("end_err", err, j.exp_err);
        chk("end_busy", busy, 1'b0);
        chk("done_after_last_b", cyc - last_b_cyc, 1);
        chk("aw_total", aw_cnt - aw0, n_aw);
        chk("w_total", w_cnt - w0, int'(j.beats));
        chk("b_total", b_cnt - b0, n_aw);
        chk("aw_queue_empty", exp_aw.size(), 0);
        chk("w_queue_empty", exp_w.size(), 0);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
    endtask

    job_t jobs[9];
    job_t after_rst;

    initial begin : main
        int n_aw, w0;
        bit got;
        jobs[0] = '{64'h0000_0000_0000_1000, 32'd32, 0,  1'b0, 1'b0, 1'b0};
        jobs[1] = '{64'h0000_0000_0000_2000, 32'd20, 0,  1'b0, 1'b0, 1'b0};
        jobs[2] = '{64'h0000_0000_0000_3000, 32'd16, 10, 1'b0, 1'b0, 1'b0};
        jobs[3] = '{64'h0000_0000_0000_8000, 32'd64, 0,  1'b0, 1'b1, 1'b0};
        jobs[4] = '{64'h0000_0000_0000_4000, 32'd32, 0,  1'b1, 1'b0, 1'b1};
        jobs[5] = '{64'h0000_0000_0000_5000, 32'd5,  0,  1'b0, 1'b0, 1'b0};
        jobs[6] = '{64'hFFFF_FFFF_FFFF_F800, 32'd32, 0,  1'b0, 1'b0, 1'b0};
        jobs[7] = '{64'h0000_0000_0000_1000, 32'd0,  0,  1'b0, 1'b0, 1'b0};
        jobs[8] = '{64'h0000_0000_0000_1040, 32'd8,  0,  1'b0, 1'b0, 1'b1};
        after_rst = '{64'h0000_0000_0000_6000, 32'd17, 0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_awvalid", bif.m_axi_awvalid, 1'b0);
        chk("rst_wvalid", bif.m_axi_wvalid, 1'b0);
        chk("rst_tready", bif.s_tready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("bready_out_of_reset", bif.m_axi_bready, 1'b1);
        chk("awid_const", bif.m_axi_awid, 16'h0000);

        for (int i = 0; i < 9; i++) run_job(jobs[i]);
        chk("err_cleared_by_start", err, 1'b1);

        // reset in the middle of a data burst
        b_hold = 1'b1;
        push_expected(64'h0000_0000_0000_9000, 32, n_aw);
        w0 = w_cnt;
        start_job(64'h0000_0000_0000_9000, 32'd32);
        got = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            #1;
            if (w_cnt - w0 >= 3 && bif.m_axi_awvalid == 1'b0) begin got = 1'b1; break; end
        end
        chk("rst_mid_reach_data", got, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_awvalid", bif.m_axi_awvalid, 1'b0);
        chk("rst_mid_wvalid", bif.m_axi_wvalid, 1'b0);
        chk("rst_mid_tready", bif.s_tready, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        resync = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("resync_done", resync, 1'b0);
        exp_aw.delete();
        exp_w.delete();
        exp_idx = src_idx;
        b_hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_job(after_rst);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcim_result_writer.md
Name: pcim_result_writer

Overview:
- Bus initiator that returns CNN results to host memory over the 512-bit PCIM AXI4 write channels (cl_sh_pcim_*).
- Consumes a 512-bit AXI-stream of result beats from the output width converter.
- Issues incrementing AXI4 write bursts to a host buffer described by a start/base/length command, and reports busy, done and error.
- Read channels (AR/R) are not part of this block.

Parameters:
- BURST_BEATS, 16, maximum beats per AXI burst (1..64). Each beat is 64 bytes, so the default burst is 1 KB.
- MAX_OUTSTANDING, 4, maximum bursts whose AW is accepted but whose B response has not yet returned (1..15).
- AXI_ID, 0, constant awid driven on every burst (16 bits).

Ports:
- clk  in  1  Design clock.
- rst_n  in  1  Asynchronous active-low reset.
- cfg_start  in  1  Single-cycle start pulse. Ignored while busy is 1.
- cfg_base_addr  in  64  Host byte address. Must be aligned to BURST_BEATS*64 bytes.
- cfg_num_beats  in  32  Total 512-bit beats to write.
- busy  out  1  High from accepted start until done.
- done  out  1  One-cycle pulse when the job completes.
- err  out  1  Sticky until the next accepted start. Set on a non-OKAY bresp or on a misaligned base address.
- s_tdata  in  512  Result stream data.
- s_tvalid  in  1  Result stream valid.
- s_tready  out  1  Result stream ready.
- m_axi_awid  out  16  Write address ID.
- m_axi_awaddr  out  64  Write address.
- m_axi_awlen  out  8  Burst length minus 1.
- m_axi_awsize  out  3  Constant 3'b110 (64 bytes).
- m_axi_awvalid  out  1  Write address valid.
- m_axi_awready  in  1  Write address ready.
- m_axi_wdata  out  512  Write data.
- m_axi_wstrb  out  64  Write strobe, all ones.
- m_axi_wlast  out  1  Last beat of burst.
- m_axi_wvalid  out  1  Write data valid.
- m_axi_wready  in  1  Write data ready.
- m_axi_bid  in  16  Response ID. Ignored.
- m_axi_bresp  in  2  Write response.
- m_axi_bvalid  in  1  Response valid.
- m_axi_bready  out  1  Response ready.

Behaviour:
- Reset state: all registered state and outputs are 0, FSM in IDLE. awvalid, wvalid, s_tready, busy, done and err are all 0.
- Reset is effective immediately at any time, including mid-burst. No completion of an in-flight burst is attempted.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - On cfg_start: latch the address and remaining beat count, clear err, set busy.
  - If cfg_num_beats==0: pulse done the next cycle, clear busy, stay in IDLE, no AXI traffic.
  - If the base address is misaligned: set err, pulse done, clear busy, stay in IDLE, no AXI traffic.
  - Otherwise go to ADDR.
- ADDR:
  - Wait until outstanding < MAX_OUTSTANDING, then assert awvalid.
  - awaddr = current address; awlen = min(BURST_BEATS, remaining) - 1.
  - awaddr, awlen and awvalid hold stable until awready.
  - On the handshake: outstanding += 1 and go to DATA.
- DATA:
  - wdata = s_tdata, wvalid = s_tvalid, s_tready = wready. Combinational pass-through, zero latency.
  - The beat counter advances on each wvalid&wready; wlast is asserted on beat awlen.
  - On the last-beat handshake: address += (awlen+1)*64 and remaining -= awlen+1.
  - If remaining is now 0 go to DRAIN, else go to ADDR.
  - W beats of a burst are never driven before that burst's AW handshake.
- DRAIN:
  - Wait for outstanding==0, then pulse done for one cycle, clear busy and go to IDLE.
- B channel:
  - bready is tied to 1 whenever out of reset.
  - Each bvalid decrements outstanding.
  - If AW acceptance and a B response occur in the same cycle, outstanding is unchanged.
  - bresp != 0 sets err; the job still runs to completion.
- s_tready is 0 outside DATA.
- Each burst is at most 4 KB and starts BURST_BEATS*64-aligned, so no burst crosses a 4 KB boundary.
- Arithmetic:
  - The remaining counter is 32 bits and never underflows.
  - The address is 64 bits and wraps modulo 2^64 with no error.

Test Plan:
- base 0x1000, beats 32, BURST_BEATS 16 -> AW 0x1000 len 15, then AW 0x1400 len 15; wlast on beats 16 and 32; done pulses 1 cycle after the 2nd B; err 0.
- base 0x2000, beats 20 -> AW 0x2000 len 15, then AW 0x2400 len 3; exactly 20 W beats; done once.
- awready held low 10 cycles -> awvalid, awaddr and awlen stable throughout; s_tready 0 and wvalid 0 until the AW handshake.
- MAX_OUTSTANDING 2, beats 64, B withheld -> 3rd AW not asserted until the first B; 4 B responses total before done.
- 1st bresp=2'b10, beats 32 -> err=1, done still pulses after all bursts; next cfg_start clears err.
- beats 0 -> done 1 cycle after start, no AW. base 0x1040 -> err=1 and done, no AW. rst_n low mid-DATA -> awvalid, wvalid and busy go to 0 immediately; the next start runs normally.
